bcd_countdown_timer: RTL



---
 rtl/timer_pkg.sv | 19 +
 rtl/bcd_down_digit.sv | 24 ++
 rtl/bcd_countdown_timer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  // Digit vector, index 0 = ones, 1 = tens, 2 = hundreds
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  // Saturate a digit value to an upper limit
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v,
                                                     input logic [DIGIT_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: parallel load, decrement, wrap to max at zero.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec_en,
  input  logic [DIGIT_W-1:0] max,
  output logic [DIGIT_W-1:0] q,
  output logic               is_zero
);

  // Load has priority over decrement; a decrement from zero borrows and reloads max
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    q <= '0;
    else if (load)   q <= load_val;
    else if (dec_en) q <= (q == '0) ? max : q - DIGIT_W'(1);
  end

  assign is_zero = (q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Three-digit cascaded BCD countdown timer with load/start/stop control,
// expiry pulse, sticky done and optional auto-reload.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               load,
  input  logic [DIGIT_W-1:0] preset0,
  input  logic [DIGIT_W-1:0] preset1,
  input  logic [DIGIT_W-1:0] preset2,
  input  logic [DIGIT_W-1:0] max0,
  input  logic [DIGIT_W-1:0] max1,
  input  logic [DIGIT_W-1:0] max2,
  input  logic               start,
  input  logic               stop,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] hundreds,
  output logic               running,
  output logic               expired,
  output logic               done,
  output logic               borrow
);

  state_t  state;
  digits_t max_in, eff_max, preset_in, preset_clamped, store, cnt, nxt_dec, ld_val;
  logic [NUM_DIGITS-1:0] is_zero, dec_en;
  logic cnt_zero, tick_acc, dec_go, wrap, restart, dig_load, hit_zero;

  assign max_in    = {max2, max1, max0};
  assign preset_in = {preset2, preset1, preset0};
  assign cnt_zero  = &is_zero;

  // Control strobes resolved in priority order load > stop > start > tick
  always_comb begin
    tick_acc = (state == RUN) && tick && !load && !stop && !start;
    dec_go   = tick_acc && !cnt_zero;
    wrap     = tick_acc && cnt_zero && AUTO_RELOAD;
    restart  = (state == EXPIRED) && start && !load && !stop;
    dig_load = load || restart || wrap;
    ld_val   = load ? preset_clamped : store;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      // Limits above 9 are not BCD; saturate them, then bound the preset
      assign eff_max[g]        = clamp_digit(max_in[g], BCD_MAX);
      assign preset_clamped[g] = clamp_digit(preset_in[g], eff_max[g]);

      // A digit decrements only when every lower digit is borrowing
      if (g == 0) begin : g_lsd
        assign dec_en[g] = dec_go;
      end else begin : g_upper
        assign dec_en[g] = dec_en[g-1] & is_zero[g-1];
      end

      // Look-ahead of the post-tick value, used to detect arrival at 000
      assign nxt_dec[g] = dec_en[g] ? (is_zero[g] ? eff_max[g] : cnt[g] - DIGIT_W'(1))
                                    : cnt[g];

      bcd_down_digit u_digit (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (dig_load),
        .load_val (ld_val[g]),
        .dec_en   (dec_en[g]),
        .max      (eff_max[g]),
        .q        (cnt[g]),
        .is_zero  (is_zero[g])
      );
    end
  endgenerate

  assign hit_zero = dec_go && (nxt_dec == '0);

  assign ones     = cnt[0];
  assign tens     = cnt[1];
  assign hundreds = cnt[2];

  // Control FSM with registered status outputs and the preset store
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      store   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
      borrow  <= 1'b0;
    end else begin
      expired <= 1'b0;
      borrow  <= 1'b0;
      if (load) begin
        store   <= preset_clamped;
        state   <= IDLE;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (stop) begin
        if (state == RUN) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      end else if (start) begin
        case (state)
          IDLE, PAUSE: begin
            if (!cnt_zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
            // Digits reload from the store in the same cycle
            done <= 1'b0;
            if (store != '0) begin
              state   <= RUN;
              running <= 1'b1;
            end else begin
              state   <= IDLE;
              running <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (tick_acc) begin
        if (wrap) begin
          borrow <= 1'b1;
        end else if (hit_zero) begin
          expired <= 1'b1;
          if (!AUTO_RELOAD) begin
            state   <= EXPIRED;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
      end
    end
  end

endmodule
